// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, RV32I byte/half/word access on a word RAM, valid/ready response out.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors instead of forcing alignment.
module dmem_responder #(
    parameter int    RAM_WIDTH       = 32,
    parameter int    RAM_ADDR_BITS   = 9,
    parameter string DATA_FILE       = "",
    parameter int    INIT_START_ADDR = 10,
    parameter int    INIT_END_ADDR   = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [2:0]           req_funct3,
    input  logic [RAM_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RAM_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err
);

    localparam int DEPTH  = 1 << RAM_ADDR_BITS;
    localparam int AW     = RAM_ADDR_BITS + 2;
    localparam int NBYTES = RAM_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     we_q;
    logic [AW-1:0]            addr_q;
    logic [2:0]               funct3_q;
    logic [RAM_WIDTH-1:0]     wdata_q;
    logic [RAM_WIDTH-1:0]     mem [DEPTH];
    logic [RAM_WIDTH-1:0]     word_q;
    logic [RAM_ADDR_BITS-1:0] idx;
    logic                     illegal, misalign, acc_err, mem_we;
    logic [NBYTES-1:0]        be;
    logic [RAM_WIDTH-1:0]     wdata_rep;
    logic [7:0]               byte_sel;
    logic [15:0]              half_sel;
    logic [RAM_WIDTH-1:0]     load_val;
    logic                     unused_addr;

    // Bytes above the RAM span are ignored, so addresses wrap.
    assign unused_addr = ^req_addr[31:AW];
    assign idx         = addr_q[AW-1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                we_q     <= req_we;
                addr_q   <= req_addr[AW-1:0];
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ACCESS;
            end
            ACCESS: state_d = RESP;
            RESP:   if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        illegal  = we_q ? (funct3_q[2] || funct3_q[1:0] == 2'b11)
                        : (funct3_q == 3'b011 || funct3_q[2:1] == 2'b11);
        misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (funct3_q[1:0] == 2'b01 && addr_q[0]) ||
                   (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`endif
        acc_err  = illegal || misalign;
    end

    // Narrow stores replicate their data across the word; the byte enables pick the lane.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    assign mem_we = (state_q == ACCESS) && we_q && !acc_err;

    always_ff @(posedge clk) begin
        if (state_q == ACCESS) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (mem_we && be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
            word_q <= mem[idx];
        end
    end

    always_comb begin
        byte_sel = word_q[8*addr_q[1:0] +: 8];
        half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = word_q;
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = '0;
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && acc_err;
    assign rsp_rdata = (rsp_valid && !we_q && !acc_err) ? load_val : '0;

endmodule
